// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: out = in1 - in2 - bin, bout is the borrow out.
module full_subtractor (
    input  logic in1,
    input  logic in2,
    input  logic bin,
    output logic out,
    output logic bout
);

    always_comb begin
        out  = in1 ^ in2 ^ bin;
        bout = (~in1 & in2) | (~(in1 ^ in2) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: in1 - in2 computed LSB-first through one
// full-subtractor cell, WIDTH cycles per operation, one-cycle done pulse.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-2:0] r;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bnext;
    logic [WIDTH-1:0] r_shift;

    full_subtractor u_cell (
        .in1  (a[0]),
        .in2  (b[0]),
        .bin  (br),
        .out  (d),
        .bout (bnext)
    );

    // The result register keeps only the WIDTH-1 bits still needed; the
    // bit a full-width shifter would drop off the bottom is never observed.
    always_comb begin
        r_shift = {d, r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            r     <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            bout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= in1;
                        b     <= in2;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r   <= r_shift[WIDTH-1:1];
                    a   <= a >> 1;
                    b   <= b >> 1;
                    br  <= bnext;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out   <= r_shift;
                        bout  <= bnext;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: vector table and corner sequences at WIDTH=8,
// exhaustive operand sweep at WIDTH=4; results checked through scoreboards.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] in1;
        logic [7:0] in2;
        logic [7:0] exp_out;
        logic       exp_bout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] out8;
    logic       bout8;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] out4;
    logic       bout4;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt8 = 0;
    logic [8:0] sb8[$];
    logic [4:0] sb4[$];
    logic [8:0] e8;
    logic [4:0] e4;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .in1   (a8),
        .in2   (b8),
        .busy  (busy8),
        .done  (done8),
        .out   (out8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .in1   (a4),
        .in2   (b4),
        .busy  (busy4),
        .done  (done4),
        .out   (out4),
        .bout  (bout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            check("sb8_has_entry", 32'(sb8.size() != 0), 32'd1);
            if (sb8.size() != 0) begin
                e8 = sb8.pop_front();
                check("out8", 32'(out8), 32'(e8[7:0]));
                check("bout8", 32'(bout8), 32'(e8[8]));
            end
        end
        if (done4) begin
            check("sb4_has_entry", 32'(sb4.size() != 0), 32'd1);
            if (sb4.size() != 0) begin
                e4 = sb4.pop_front();
                check("out4", 32'(out4), 32'(e4[3:0]));
                check("bout4", 32'(bout4), 32'(e4[4]));
            end
        end
    end

    task automatic wait_done8(input int init, output int lat);
        lat = init;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input vec_t v);
        start8 = 1'b1;
        a8 = v.in1;
        b8 = v.in2;
        sb8.push_back({v.exp_bout, v.exp_out});
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~v.in1;
        b8 = 8'($urandom);
        check("busy8_after_start", 32'(busy8), 32'd1);
        begin
            int lat;
            wait_done8(0, lat);
            check("latency8", lat, 32'd8);
        end
        check("busy8_at_done", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        check("done8_one_cycle", 32'(done8), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   snap;

        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[4] = '{8'h10, 8'h05, 8'h0B, 1'b0};
        vecs[5] = '{8'hC3, 8'h3C, 8'h87, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0;
        b8 = '0;
        a4 = '0;
        b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_out", 32'(out8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i]);
        end

        // Reset during RUN cycle 4 (out/bout currently hold FF/1)
        snap = done_cnt8;
        start8 = 1'b1;
        a8 = 8'h33;
        b8 = 8'h11;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_out", 32'(out8), 32'd0);
        check("midrst_bout", 32'(bout8), 32'd0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("midrst_no_done", done_cnt8, snap);

        // Reset and start together: reset wins
        rst = 1'b1;
        start8 = 1'b1;
        a8 = 8'h44;
        b8 = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0;
        start8 = 1'b0;
        check("rst_start_busy", 32'(busy8), 32'd0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("rst_start_no_done", done_cnt8, snap);

        // Start during RUN cycle 3 is ignored
        snap = done_cnt8;
        start8 = 1'b1;
        a8 = 8'h10;
        b8 = 8'h05;
        sb8.push_back({1'b0, 8'h0B});
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        start8 = 1'b1;
        a8 = 8'h01;
        b8 = 8'h02;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(3, lat);
        check("ignored_latency", lat, 32'd8);
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("ignored_single_done", done_cnt8 - snap, 32'd1);

        // Back-to-back: start held high through done with new operands
        start8 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h23;
        sb8.push_back({1'b0, 8'h37});
        @(posedge clk); #1;
        a8 = 8'h80;
        b8 = 8'h7F;
        wait_done8(0, lat);
        check("b2b_first_latency", lat, 32'd8);
        sb8.push_back({1'b0, 8'h01});
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(1, lat);
        check("b2b_interval", lat, 32'd9);
        @(posedge clk); #1;

        // WIDTH=4 exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [3:0] ai;
                logic [3:0] bj;
                ai = 4'(i);
                bj = 4'(j);
                start4 = 1'b1;
                a4 = ai;
                b4 = bj;
                sb4.push_back({(i < j) ? 1'b1 : 1'b0, ai - bj});
                @(posedge clk); #1;
                start4 = 1'b0;
                lat = 0;
                while (!done4 && lat < 20) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check("latency4", lat, 32'd4);
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb8_drained", sb8.size(), 32'd0);
        check("sb4_drained", sb4.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
